// File: rtl/mips32_pipe_p.sv
// mips32_pipe_p: five-stage in-order MIPS-like core with local IMEM/DMEM, one instruction per clock at best.
// Latency IF->WB is 5 clocks; ID interlocks on RAW hazards, taken branches cost 2 bubbles, run=0 freezes everything.
module mips32_pipe_p #(
    parameter int DW         = 32,
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 64,
    parameter int NREG       = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          run,
    input  logic                          prog_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
    input  logic [31:0]                   prog_data,
    input  logic [$clog2(NREG)-1:0]       dbg_addr,
    output logic [DW-1:0]                 dbg_data,
    output logic                          retire,
    output logic                          halted
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);
    localparam int RAW = $clog2(NREG);

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_MUL   = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_J     = 6'b010000;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    logic [31:0]    imem [IMEM_DEPTH];
    logic [DW-1:0]  dmem [DMEM_DEPTH];
    logic [DW-1:0]  regs [NREG];

    logic [IAW-1:0] pc;
    logic           fetch_stop;

    logic           ifid_vld;
    logic [31:0]    ifid_ir;
    logic [IAW-1:0] ifid_npc;

    logic           idex_vld;
    logic [5:0]     idex_op;
    logic [DW-1:0]  idex_a;
    logic [DW-1:0]  idex_b;
    logic [DW-1:0]  idex_imm;
    logic [IAW-1:0] idex_npc;
    logic           idex_wr;
    logic [RAW-1:0] idex_dst;

    logic           exmem_vld;
    logic [5:0]     exmem_op;
    logic [DW-1:0]  exmem_res;
    logic [DW-1:0]  exmem_b;
    logic           exmem_wr;
    logic [RAW-1:0] exmem_dst;

    logic           memwb_vld;
    logic [5:0]     memwb_op;
    logic [DW-1:0]  memwb_res;
    logic           memwb_wr;
    logic [RAW-1:0] memwb_dst;

    logic           adv;
    assign adv = run && !halted;

    // ---------------- ID: decode, operand read, interlock ----------------
    logic [5:0]     id_op;
    logic [RAW-1:0] id_rs, id_rt, id_rd, id_dst;
    logic [DW-1:0]  id_imm;
    logic           id_rtype, id_iwr, id_wr, id_use_rs, id_use_rt;
    logic           hit_rs, hit_rt, id_stall, id_hlt;

    assign id_op = ifid_ir[31:26];
    assign id_rs = ifid_ir[21 +: RAW];
    assign id_rt = ifid_ir[16 +: RAW];
    assign id_rd = ifid_ir[11 +: RAW];

    always_comb begin
        id_rtype  = (id_op == OP_ADD) || (id_op == OP_SUB) || (id_op == OP_AND) ||
                    (id_op == OP_MUL) || (id_op == OP_SLT);
        id_iwr    = (id_op == OP_ADDI) || (id_op == OP_SUBI) || (id_op == OP_SLTI) ||
                    (id_op == OP_LW);
        id_wr     = id_rtype || id_iwr;
        id_dst    = id_rtype ? id_rd : id_rt;
        id_use_rs = id_rtype || id_iwr || (id_op == OP_SW) ||
                    (id_op == OP_BEQZ) || (id_op == OP_BNEQZ);
        id_use_rt = id_rtype || (id_op == OP_SW);
        id_imm    = (id_op == OP_J) ? DW'($signed(ifid_ir[25:0])) : DW'($signed(ifid_ir[15:0]));
    end

    // No write-through from WB, so a writer still in WB must also block the read.
    assign hit_rs = (id_rs != '0) &&
                    ((idex_vld  && idex_wr  && (idex_dst  == id_rs)) ||
                     (exmem_vld && exmem_wr && (exmem_dst == id_rs)) ||
                     (memwb_vld && memwb_wr && (memwb_dst == id_rs)));
    assign hit_rt = (id_rt != '0) &&
                    ((idex_vld  && idex_wr  && (idex_dst  == id_rt)) ||
                     (exmem_vld && exmem_wr && (exmem_dst == id_rt)) ||
                     (memwb_vld && memwb_wr && (memwb_dst == id_rt)));
    assign id_stall = ifid_vld && ((id_use_rs && hit_rs) || (id_use_rt && hit_rt));
    assign id_hlt   = ifid_vld && (id_op == OP_HLT);

    // ---------------- EX: ALU and branch resolution ----------------
    logic [DW-1:0]  ex_res;
    logic           ex_taken;
    logic [IAW-1:0] ex_target;

    always_comb begin
        ex_res = '0;
        case (idex_op)
            OP_ADD:                  ex_res = idex_a + idex_b;
            OP_SUB:                  ex_res = idex_a - idex_b;
            OP_AND:                  ex_res = idex_a & idex_b;
            OP_MUL:                  ex_res = idex_a * idex_b;
            OP_SLT:                  ex_res = DW'(idex_a < idex_b);
            OP_LW, OP_SW, OP_ADDI:   ex_res = idex_a + idex_imm;
            OP_SUBI:                 ex_res = idex_a - idex_imm;
            OP_SLTI:                 ex_res = DW'(idex_a < idex_imm);
            default:                 ex_res = '0;
        endcase
    end

    assign ex_taken  = idex_vld && ((idex_op == OP_J) ||
                                    ((idex_op == OP_BEQZ)  && (idex_a == '0)) ||
                                    ((idex_op == OP_BNEQZ) && (idex_a != '0)));
    assign ex_target = idex_npc + idex_imm[IAW-1:0];

    // ---------------- MEM ----------------
    logic [DW-1:0] mem_res;
    assign mem_res = (exmem_op == OP_LW) ? dmem[exmem_res[DAW-1:0]] : exmem_res;

    assign dbg_data = regs[dbg_addr];

    // Memories keep their contents across reset; only the pipeline state is cleared.
    always_ff @(posedge clk) begin
        if (!run && prog_we)
            imem[prog_addr] <= prog_data;
        if (adv && exmem_vld && (exmem_op == OP_SW))
            dmem[exmem_res[DAW-1:0]] <= exmem_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= '0;
            fetch_stop <= 1'b0;
            retire     <= 1'b0;
            halted     <= 1'b0;
            ifid_vld   <= 1'b0;
            ifid_ir    <= '0;
            ifid_npc   <= '0;
            idex_vld   <= 1'b0;
            idex_op    <= '0;
            idex_a     <= '0;
            idex_b     <= '0;
            idex_imm   <= '0;
            idex_npc   <= '0;
            idex_wr    <= 1'b0;
            idex_dst   <= '0;
            exmem_vld  <= 1'b0;
            exmem_op   <= '0;
            exmem_res  <= '0;
            exmem_b    <= '0;
            exmem_wr   <= 1'b0;
            exmem_dst  <= '0;
            memwb_vld  <= 1'b0;
            memwb_op   <= '0;
            memwb_res  <= '0;
            memwb_wr   <= 1'b0;
            memwb_dst  <= '0;
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (!adv) begin
            retire <= 1'b0;
        end else begin
            // WB
            retire <= memwb_vld;
            if (memwb_vld && (memwb_op == OP_HLT))
                halted <= 1'b1;
            if (memwb_vld && memwb_wr && (memwb_dst != '0))
                regs[memwb_dst] <= memwb_res;

            // MEM -> WB
            memwb_vld <= exmem_vld;
            memwb_op  <= exmem_op;
            memwb_res <= mem_res;
            memwb_wr  <= exmem_wr;
            memwb_dst <= exmem_dst;

            // EX -> MEM
            exmem_vld <= idex_vld;
            exmem_op  <= idex_op;
            exmem_res <= ex_res;
            exmem_b   <= idex_b;
            exmem_wr  <= idex_wr;
            exmem_dst <= idex_dst;

            // ID -> EX: stall or flush issues a bubble
            idex_vld <= ifid_vld && !id_stall && !ex_taken;
            idex_op  <= id_op;
            idex_a   <= regs[id_rs];
            idex_b   <= regs[id_rt];
            idex_imm <= id_imm;
            idex_npc <= ifid_npc;
            idex_wr  <= id_wr;
            idex_dst <= id_dst;

            // IF: flush beats stall, stall beats halt-driven fetch stop
            if (ex_taken) begin
                pc       <= ex_target;
                ifid_vld <= 1'b0;
            end else if (id_stall) begin
                pc       <= pc;
            end else if (fetch_stop || id_hlt) begin
                ifid_vld <= 1'b0;
                if (id_hlt)
                    fetch_stop <= 1'b1;
            end else begin
                ifid_vld <= 1'b1;
                ifid_ir  <= imem[pc];
                ifid_npc <= pc + 1'b1;
                pc       <= pc + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mips32_pipe_p.sv
// Directed program tests for mips32_pipe_p; expected register values queue up at load time and drain after halt.
module tb_mips32_pipe_p;
    localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_AND = 6'b000010;
    localparam logic [5:0] OP_MUL = 6'b000011, OP_SLT = 6'b000100, OP_LW = 6'b001000;
    localparam logic [5:0] OP_SW = 6'b001001, OP_ADDI = 6'b001010, OP_SUBI = 6'b001011;
    localparam logic [5:0] OP_SLTI = 6'b001100, OP_BNEQZ = 6'b001101, OP_BEQZ = 6'b001110;
    localparam logic [5:0] OP_BAD = 6'b111110;
    localparam logic [31:0] HLT = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst_n, run, prog_we;
    logic [5:0]  prog_addr;
    logic [31:0] prog_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        retire, halted;

    always #5 clk = ~clk;

    mips32_pipe_p dut (
        .clk(clk), .rst_n(rst_n), .run(run), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .retire(retire), .halted(halted)
    );

    typedef struct {
        string       tag;
        int          r;
        logic [31:0] v;
    } exp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        sb[$];
    logic [31:0] pq[$];
    int          rets, cyc, cyc_clean;

    function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] ii(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] jj(input int imm);
        return {6'b010000, 26'(imm)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input string tag, input int r, input logic [31:0] v);
        sb.push_back('{tag, r, v});
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            dbg_addr = 5'(e.r);
            #1;
            chk(e.tag, dbg_data, e.v);
        end
    endtask

    task automatic load_prog();
        run = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            prog_we   = 1'b1;
            prog_addr = 6'(i);
            prog_data = (i < pq.size()) ? pq[i] : 32'h0;
            @(negedge clk);
        end
        prog_we = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        chk({tag, "_halted_in_rst"}, 32'(halted), 32'd0);
        chk({tag, "_retire_in_rst"}, 32'(retire), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs until halted or budget; optional run=0 window and a write attempt while running.
    task automatic run_halt(input string tag, input int budget, input int pause_at, input int pause_len,
                            input bit poke, output int n_ret, output int n_cyc);
        n_ret = 0;
        n_cyc = 0;
        run   = 1'b1;
        while (!halted && n_cyc < budget) begin
            prog_we = 1'b0;
            if (poke && n_cyc == 1) begin
                prog_we   = 1'b1;
                prog_addr = 6'd5;
                prog_data = HLT;
            end
            if (n_cyc == pause_at) run = 1'b0;
            if (n_cyc == pause_at + pause_len) run = 1'b1;
            @(posedge clk);
            @(negedge clk);
            n_cyc++;
            if (retire) n_ret++;
        end
        run     = 1'b0;
        prog_we = 1'b0;
        chk({tag, "_halted"}, 32'(halted), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; prog_we = 1'b0;
        prog_addr = '0; prog_data = '0; dbg_addr = '0;
        #12;
        chk("reset_halted", 32'(halted), 32'd0);
        chk("reset_retire", 32'(retire), 32'd0);
        dbg_addr = 5'd3; #1;
        chk("reset_r3", dbg_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // RAW interlock through ADD
        pq = {ii(OP_ADDI, 1, 0, 5), ii(OP_ADDI, 2, 0, 7), rr(OP_ADD, 3, 1, 2), HLT};
        load_prog();
        push_exp("t1_r1", 1, 32'd5); push_exp("t1_r2", 2, 32'd7); push_exp("t1_r3", 3, 32'd12);
        run_halt("t1", 200, -1, 0, 1'b0, rets, cyc);
        chk("t1_retires", 32'(rets), 32'd4);
        chk("t1_stalled", 32'(cyc > 8), 32'd1);
        drain();

        // Store then load through DMEM
        do_reset("t2");
        pq = {ii(OP_ADDI, 1, 0, 9), ii(OP_SW, 1, 0, 3), ii(OP_LW, 4, 0, 3), HLT};
        load_prog();
        push_exp("t2_r4", 4, 32'd9);
        run_halt("t2", 200, -1, 0, 1'b0, rets, cyc);
        chk("t2_retires", 32'(rets), 32'd4);
        drain();

        // DMEM survives reset, registers do not
        do_reset("t2b");
        pq = {ii(OP_LW, 7, 0, 3), HLT};
        load_prog();
        push_exp("t2b_r7", 7, 32'd9); push_exp("t2b_r4", 4, 32'd0);
        run_halt("t2b", 200, -1, 0, 1'b0, rets, cyc);
        drain();

        // Taken BEQZ flushes two shadow instructions
        do_reset("t3");
        pq = {ii(OP_BEQZ, 0, 1, 2), ii(OP_ADDI, 5, 0, 1), ii(OP_ADDI, 5, 0, 2), ii(OP_ADDI, 6, 0, 3), HLT};
        load_prog();
        push_exp("t3_r5", 5, 32'd0); push_exp("t3_r6", 6, 32'd3);
        run_halt("t3", 200, -1, 0, 1'b0, rets, cyc);
        chk("t3_retires", 32'(rets), 32'd3);
        drain();

        // HLT in the shadow of a J is discarded
        do_reset("t3b");
        pq = {jj(1), HLT, ii(OP_ADDI, 8, 0, 4), HLT};
        load_prog();
        push_exp("t3b_r8", 8, 32'd4);
        run_halt("t3b", 200, -1, 0, 1'b0, rets, cyc);
        chk("t3b_retires", 32'(rets), 32'd3);
        drain();

        // R0 stays zero
        do_reset("t4");
        pq = {ii(OP_ADDI, 1, 0, 3), ii(OP_ADDI, 0, 0, 7), rr(OP_ADD, 1, 0, 0), HLT};
        load_prog();
        push_exp("t4_r0", 0, 32'd0); push_exp("t4_r1", 1, 32'd0);
        run_halt("t4", 200, -1, 0, 1'b0, rets, cyc);
        drain();

        // ALU ops, unsigned compares, unknown opcode as NOP, prog_we ignored while running
        do_reset("t5");
        pq = {ii(OP_ADDI, 1, 0, 6), ii(OP_ADDI, 2, 0, -2), rr(OP_MUL, 3, 1, 2), rr(OP_SUB, 4, 1, 2),
              rr(OP_AND, 5, 1, 2), rr(OP_SLT, 6, 1, 2), ii(OP_SLTI, 7, 2, 5), ii(OP_SUBI, 8, 1, 1),
              ii(OP_BAD, 9, 1, 1), ii(OP_SLTI, 10, 1, -1), HLT};
        load_prog();
        push_exp("t5_mul", 3, 32'hFFFF_FFF4); push_exp("t5_sub", 4, 32'd8);
        push_exp("t5_and", 5, 32'd6);         push_exp("t5_slt", 6, 32'd1);
        push_exp("t5_slti0", 7, 32'd0);       push_exp("t5_subi", 8, 32'd5);
        push_exp("t5_nop", 9, 32'd0);         push_exp("t5_slti1", 10, 32'd1);
        run_halt("t5", 300, -1, 0, 1'b1, rets, cyc);
        chk("t5_retires", 32'(rets), 32'd11);
        drain();

        // Countdown loop, clean and with a 5-cycle freeze
        do_reset("t6");
        pq = {ii(OP_ADDI, 1, 0, 3), ii(OP_SUBI, 1, 1, 1), ii(OP_BNEQZ, 0, 1, -2), HLT};
        load_prog();
        push_exp("t6_r1", 1, 32'd0);
        run_halt("t6", 400, -1, 0, 1'b0, rets, cyc_clean);
        chk("t6_retires", 32'(rets), 32'd8);
        drain();

        do_reset("t6p");
        load_prog();
        push_exp("t6p_r1", 1, 32'd0);
        run_halt("t6p", 400, 6, 5, 1'b0, rets, cyc);
        chk("t6p_retires", 32'(rets), 32'd8);
        chk("t6p_cycles", 32'(cyc), 32'(cyc_clean + 5));
        drain();

        // Reset in mid-flight, then reload and rerun
        do_reset("t7");
        pq = {ii(OP_ADDI, 1, 0, 5), ii(OP_ADDI, 2, 0, 7), rr(OP_ADD, 3, 1, 2), HLT};
        load_prog();
        run = 1'b1;
        repeat (7) @(negedge clk);
        dbg_addr = 5'd1; #1;
        chk("t7_r1_before_rst", dbg_data, 32'd5);
        rst_n = 1'b0;
        #1;
        chk("t7_r1_async_clr", dbg_data, 32'd0);
        chk("t7_halted_in_rst", 32'(halted), 32'd0);
        @(negedge clk);
        run = 1'b0;
        rst_n = 1'b1;
        load_prog();
        push_exp("t7_r3", 3, 32'd12); push_exp("t7_r2", 2, 32'd7);
        run_halt("t7", 200, -1, 0, 1'b0, rets, cyc);
        chk("t7_retires", 32'(rets), 32'd4);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
